// File: rtl/a429_pkg.sv
// Shared definitions for the ARINC 429 transmitter: state encoding,
// default timing parameters and the on-wire bit ordering helper.
package a429_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_GAP  = 2'd2
  } a429_state_e;

  localparam int unsigned DIV_HI_DEF   = 250;   // 100 kbps at 50 MHz
  localparam int unsigned DIV_LO_DEF   = 2000;  // 12.5 kbps at 50 MHz
  localparam int unsigned GAP_BITS_DEF = 4;

  // Reorders a word so that bit i is the i-th bit on the wire: label bits
  // 7..0 first (MSB first), then 8..31, with optional odd parity in bit 31.
  function automatic logic [31:0] tx_order(input logic [31:0] word, input logic par_ena);
    logic [31:0] seq;
    for (int i = 0; i < 8; i++) seq[i] = word[7-i];
    seq[31:8] = word[31:8];
    if (par_ena) seq[31] = ~^word[30:0];
    return seq;
  endfunction

endpackage

// File: rtl/a429_baud.sv
// Half-bit tick generator: down-counter reloaded with div-1 on restart or
// on reaching zero, producing a single-cycle tick every div cycles.
module a429_baud (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] div,
  input  logic        restart,
  output logic        tick
);

  logic [15:0] cnt_q;

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i)                         cnt_q <= '0;
    else if (restart || cnt_q == '0)   cnt_q <= div - 16'd1;
    else                               cnt_q <= cnt_q - 16'd1;
  end

  // Reloading at zero (never decrementing past it) avoids a wrap to 16'hFFFF.
  assign tick = (cnt_q == '0) && !restart;

endmodule

// File: rtl/a429_tx.sv
// ARINC 429 bipolar RZ word transmitter fed from a first-word-fall-through
// FIFO; sends 32-bit words with a minimum null gap between them.
module a429_tx
  import a429_pkg::*;
#(
  parameter int unsigned DIV_HI   = DIV_HI_DEF,
  parameter int unsigned DIV_LO   = DIV_LO_DEF,
  parameter int unsigned PAR_ENA  = 1,
  parameter int unsigned GAP_BITS = GAP_BITS_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tx_ena,
  input  logic        tx_hi_spd,
  input  logic [31:0] tf_do,
  input  logic        tf_et,
  output logic        tf_rd,
  output logic        tx_hi,
  output logic        tx_lo,
  output logic        tx_busy,
  output logic        tx_done
);

  localparam logic [15:0] DIV_HI_W = 16'(DIV_HI);
  localparam logic [15:0] DIV_LO_W = 16'(DIV_LO);
  localparam logic [5:0]  GAP_LAST = 6'(2 * GAP_BITS - 1);

  a429_state_e state_q, state_d;
  logic [31:0] shift_q;
  logic [5:0]  half_q;
  logic        spd_q;
  logic        hold_q;
  logic        tick;
  logic        pop;
  logic        last_data;
  logic        last_gap;
  logic [15:0] div_sel;

  // hold_q forces one IDLE cycle after every gap before the next pop.
  assign pop       = (state_q == ST_IDLE) && tx_ena && !tf_et && !hold_q && !rst_i;
  assign last_data = (state_q == ST_DATA) && tick && (half_q == 6'd63);
  assign last_gap  = (state_q == ST_GAP)  && tick && (half_q == GAP_LAST);
  assign div_sel   = ((state_q == ST_IDLE) ? tx_hi_spd : spd_q) ? DIV_HI_W : DIV_LO_W;

  a429_baud u_baud (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .div     (div_sel),
    .restart (pop),
    .tick    (tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pop)       state_d = ST_DATA;
      ST_DATA: if (last_data) state_d = ST_GAP;
      ST_GAP:  if (last_gap)  state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      half_q  <= '0;
      spd_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      hold_q <= last_gap;
      if (pop) begin
        shift_q <= tx_order(tf_do, PAR_ENA != 0);
        spd_q   <= tx_hi_spd;
        half_q  <= '0;
      end else if (state_q != ST_IDLE && tick) begin
        // 63 -> 0 wraps naturally, so the gap count starts from zero.
        half_q <= half_q + 6'd1;
        if (state_q == ST_DATA && half_q[0]) shift_q <= shift_q >> 1;
      end
    end
  end

  always_comb begin
    tf_rd   = pop;
    tx_busy = (state_q != ST_IDLE);
    tx_done = last_data;
    tx_hi   = (state_q == ST_DATA) && !half_q[0] &&  shift_q[0];
    tx_lo   = (state_q == ST_DATA) && !half_q[0] && !shift_q[0];
  end

endmodule
